// File: rtl/bsg_lru_pseudo_tree_encode_reg.sv
// Registered tree-PLRU encoder: walks the heap-ordered PLRU bits of one set
// from the root and registers the binary index of the victim way.
module bsg_lru_pseudo_tree_encode_reg #(
    parameter int ways_p     = 8,
    parameter int lg_ways_lp = (ways_p > 1) ? $clog2(ways_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    input  logic [ways_p-2:0]     lru_i,
    output logic                  v_o,
    output logic [lg_ways_lp-1:0] way_id_o
);

    // Node indices reach 2*ways_p-2 on the final step, so the tree is padded
    // to a power of two and the index width matches it exactly.
    localparam int NODE_W = lg_ways_lp + 1;

    logic [2*ways_p-1:0]  w_tree;
    logic [NODE_W-1:0]    w_node;
    logic [lg_ways_lp-1:0] w_way_id_p0;

    logic                  r_vld_p1;
    logic [lg_ways_lp-1:0] r_way_id_p1;

    assign w_tree = {{(ways_p + 1){1'b0}}, lru_i};

    always_comb begin
        w_node      = '0;
        w_way_id_p0 = '0;
        for (int d = 0; d < lg_ways_lp; d++) begin
            w_way_id_p0[lg_ways_lp-1-d] = w_tree[w_node];
            w_node = {w_node[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(w_tree[w_node]);
        end
    end

    // p0 -> p1: result register; the index holds while no valid input arrives
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_vld_p1    <= 1'b0;
            r_way_id_p1 <= '0;
        end else begin
            r_vld_p1 <= v_i;
            if (v_i) begin
                r_way_id_p1 <= w_way_id_p0;
            end
        end
    end

    assign v_o      = r_vld_p1;
    assign way_id_o = r_way_id_p1;

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_encode_reg.sv
// Scoreboard bench for the PLRU encoder: ways_p = 2, 4, 8 and 16 side by side,
// directed vectors on the 8-way instance, exhaustive sweeps on all four.
module tb_bsg_lru_pseudo_tree_encode_reg;

    typedef struct {
        int way;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       v_i_a = '0;
    logic [3:0][14:0] lru_a = '0;
    logic [3:0]       v_o_a;
    logic [3:0][3:0]  way_a;

    exp_t q[4][$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W  = 2 << g;
        localparam int LG = g + 1;
        logic [LG-1:0] w_way;
        logic          w_v;
        bsg_lru_pseudo_tree_encode_reg #(.ways_p(W)) u_dut (
            .clk_i   (clk),
            .reset_i (reset),
            .v_i     (v_i_a[g]),
            .lru_i   (lru_a[g][W-2:0]),
            .v_o     (w_v),
            .way_id_o(w_way)
        );
        assign v_o_a[g] = w_v;
        assign way_a[g] = 4'(w_way);
    end

    // Heap-index reference: node at depth d is (2^d - 1) + path-so-far.
    function automatic int ref_walk(input int ways, input logic [14:0] lru);
        int lg;
        int way;
        int node;
        lg  = $clog2(ways);
        way = 0;
        for (int d = 0; d < lg; d++) begin
            node = (1 << d) - 1 + way;
            way  = (way << 1) | int'(lru[node[3:0]]);
        end
        return way;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (v_o_a[k] === 1'b1) begin
                n_checks++;
                if (q[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_vo ways=%0d got way=%0d, no result required, cyc=%0d",
                             2 << k, way_a[k], cyc);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    if (int'(way_a[k]) != e.way || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL way_id ways=%0d got=%0d@cyc%0d required=%0d@cyc%0d",
                                 2 << k, way_a[k], cyc, e.way, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic issue(input int idx, input logic [14:0] lru, input logic v, input int exp_way);
        @(posedge clk);
        #1;
        v_i_a      = '0;
        v_i_a[idx] = v;
        lru_a[idx] = lru;
        if (v) q[idx].push_back('{exp_way, cyc + 1});
    endtask

    logic [6:0] vec_lru[18] = '{
        7'b000_0000, 7'b111_0100, 7'b000_1000, 7'b110_1010, 7'b111_0110,
        7'b000_0001, 7'b011_1011, 7'b011_1101, 7'b100_0101, 7'b111_1111,
        7'b000_0000, 7'b000_1000, 7'b110_1010, 7'b111_0110,
        7'b000_0001, 7'b011_1011, 7'b011_1101, 7'b100_0101
    };
    int vec_way[18] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 0, 1, 2, 3, 4, 5, 6, 7};

    initial begin
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_vo_w%0d", 2 << k), int'(v_o_a[k]), 0);
            chk($sformatf("reset_way_w%0d", 2 << k), int'(way_a[k]), 0);
        end
        #12 reset = 1'b0;

        for (int i = 0; i < 18; i++) issue(2, 15'(vec_lru[i]), 1'b1, vec_way[i]);

        // drop v_i with a different pattern on lru_i: index must hold at 7
        issue(2, 15'(0), 1'b0, 0);
        @(posedge clk);
        #1;
        chk("hold_vo", int'(v_o_a[2]), 0);
        chk("hold_way", int'(way_a[2]), 7);

        issue(2, 15'(7'b011_1011), 1'b1, 5);
        #2 reset = 1'b1;
        #1;
        chk("midreset_vo", int'(v_o_a[2]), 0);
        chk("midreset_way", int'(way_a[2]), 0);
        q[2].delete();
        lru_a[2] = 15'(7'b011_1101);
        @(posedge clk);
        #1;
        chk("inreset_vo", int'(v_o_a[2]), 0);
        chk("inreset_way", int'(way_a[2]), 0);
        #2 reset = 1'b0;
        q[2].push_back('{6, cyc + 1});
        issue(2, 15'(0), 1'b0, 0);
        issue(2, 15'(0), 1'b0, 0);

        for (int k = 0; k < 4; k++) begin
            int w;
            w = 2 << k;
            for (int v = 0; v < (1 << (w - 1)); v++) begin
                issue(k, 15'(v), 1'b1, ref_walk(w, 15'(v)));
            end
            issue(k, 15'(0), 1'b0, 0);
        end
        issue(0, 15'(0), 1'b0, 0);
        issue(0, 15'(0), 1'b0, 0);

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pending_results_w%0d", 2 << k), q[k].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
